wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters:
- DATA_W, default 32, register data width.
- ADDR_W, default 5, register address width; register count = 2^ADDR_W.

REQ-002 The block SHALL have one clock and a synchronous, active-high reset. Ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- a_we  in  1  pipeline writeback write enable.
- a_waddr  in  ADDR_W  pipeline writeback address.
- a_wdata  in  DATA_W  pipeline writeback data.
- b_valid  in  1  long-latency unit result valid.
- b_waddr  in  ADDR_W  long-latency result address.
- b_wdata  in  DATA_W  long-latency result data.
- b_ready  out  1  long-latency result accepted this cycle.
- iss_valid  in  1  long-latency op issued; marks destination busy.
- iss_waddr  in  ADDR_W  destination of issued op.
- re1, re2  in  1 each  decode read enables.
- raddr1, raddr2  in  ADDR_W each  decode read addresses.
- stall_o  out  1  decode must hold.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- busy_o  out  2^ADDR_W  scoreboard bits.

Function
REQ-003 The block SHALL hold a one-entry B buffer (buf_v, buf_addr, buf_data) and a scoreboard busy[2^ADDR_W-1:0]; busy[0] SHALL be constant 0.
REQ-004 An A request SHALL be qualified as a_req = a_we && a_waddr != 0; an A write to register 0 SHALL be dropped and SHALL NOT occupy the write port.
REQ-005 Port grant SHALL use fixed priority, A over buffer: a_req drives rf_we=1, rf_waddr=a_waddr, rf_wdata=a_wdata in the same cycle (combinational, zero latency).
REQ-006 If !a_req and buf_v, the buffer SHALL drive the write port that cycle (drain) and buf_v SHALL clear at the next edge unless refilled.
REQ-007 If neither a_req nor buf_v, rf_we SHALL be 0, and rf_waddr and rf_wdata SHALL be 0.
REQ-008 b_ready SHALL equal !rst && (!buf_v || drain); B is accepted when b_valid && b_ready and SHALL be captured into the buffer at that edge.
REQ-009 B-to-register-file latency SHALL be at least 1 cycle, and exactly 1 when A is idle. Sustained throughput SHALL be one B result per cycle while A is idle.
REQ-010 A B result with b_waddr == 0 SHALL be accepted and discarded: not buffered, no write, no scoreboard change.
REQ-011 On a cycle with drain, busy[buf_addr] SHALL clear at the next edge.
REQ-012 iss_valid && iss_waddr != 0 && !stall_o SHALL set busy[iss_waddr] at the next edge.
REQ-013 When set and clear target the same index in the same cycle, set SHALL win.
REQ-014 Effective busy SHALL be defined as eff_busy = busy & ~(drain ? onehot(buf_addr) : 0). The drained register's reader is served by the register file's same-cycle bypass.
REQ-015 stall_o SHALL be asserted when any of the following holds:
- re1 && raddr1 != 0 && eff_busy[raddr1];
- re2 && raddr2 != 0 && eff_busy[raddr2];
- iss_valid && iss_waddr != 0 && eff_busy[iss_waddr] (WAW).
REQ-016 While stall_o is 1, the issue SHALL be ignored; the pipeline re-presents it.
REQ-017 stall_o SHALL be purely combinational from current inputs and state.
REQ-018 An A write to a busy register SHALL be performed. busy SHALL be unchanged, because the pending long-latency result owns the register.
REQ-019 While A holds the port, a full buffer SHALL hold its entry indefinitely and b_ready SHALL stay 0. Data and address SHALL remain stable.
REQ-020 busy_o SHALL reflect the registered busy, not eff_busy.

Reset
REQ-021 While rst=1:
- buf_v=0 and busy=0;
- rf_we=0, rf_waddr=0, rf_wdata=0;
- b_ready=0, stall_o=0, busy_o=0.
REQ-022 Reset asserted mid-operation SHALL discard any buffered B entry without writing it, and SHALL clear all pending busy bits at that edge.
REQ-023 The first non-reset cycle SHALL behave as idle: rf_we=0 and b_ready=1.

Verification
REQ-024 Idle drain: issue r5 (iss_valid=1, iss_waddr=5) in cycle 0, so busy_o[5]=1 in cycle 1. Then:
- b_valid, b_waddr=5, b_wdata=0xDEADBEEF in cycle 2 -> b_ready=1 in cycle 2;
- rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle 3;
- busy_o[5]=0 in cycle 4.
REQ-025 Conflict: buffer holds r7=0x11, and a_we with a_waddr=3, a_wdata=0x22 is held for 3 cycles -> rf writes r3 for those 3 cycles; b_ready=0; r7 is written in cycle 4.
REQ-026 RAW stall: busy[9]=1, re1=1, raddr1=9 -> stall_o=1. In the drain cycle for r9, stall_o=0.
REQ-027 WAW and register 0:
- iss_waddr=4 with busy[4]=1 -> stall_o=1 and busy unchanged;
- iss_waddr=0 -> no stall, no set;
- a_we with a_waddr=0 while buf_v -> buffer drains.
REQ-028 Same-cycle set/clear: drain of r6 while iss_valid, iss_waddr=6, stall_o=0 -> busy_o[6]=1 next cycle.
REQ-029 Reset mid-op: buf_v=1 and busy=0x0000_0280, rst pulsed for 1 cycle -> no rf write, busy_o=0, and b_ready=1 the following cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Register-file write-port arbiter between the in-order
//                pipeline writeback (port A) and a long-latency unit (port B).
//                Port B results pass through a one-entry buffer. A busy
//                scoreboard tracks outstanding long-latency destinations and
//                produces the decode stall for RAW and WAW hazards.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    // pipeline writeback
    input  logic                     a_we,
    input  logic [ADDR_W-1:0]        a_waddr,
    input  logic [DATA_W-1:0]        a_wdata,
    // long-latency result
    input  logic                     b_valid,
    input  logic [ADDR_W-1:0]        b_waddr,
    input  logic [DATA_W-1:0]        b_wdata,
    output logic                     b_ready,
    // long-latency issue
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_waddr,
    // decode reads
    input  logic                     re1,
    input  logic                     re2,
    input  logic [ADDR_W-1:0]        raddr1,
    input  logic [ADDR_W-1:0]        raddr2,
    output logic                     stall_o,
    // register file write port
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    // scoreboard
    output logic [(1<<ADDR_W)-1:0]   busy_o
);

    localparam int                 c_NREG      = 1 << ADDR_W;
    localparam logic [c_NREG-1:0]  c_ONE       = {{(c_NREG-1){1'b0}}, 1'b1};
    localparam logic [c_NREG-1:0]  c_BIT0_MASK = ~c_ONE;

    // buffer and scoreboard state
    logic                r_buf_v;
    logic [ADDR_W-1:0]   r_buf_addr;
    logic [DATA_W-1:0]   r_buf_data;
    logic [c_NREG-1:0]   r_busy;

    // combinational control
    logic                w_a_req;
    logic                w_drain;
    logic                w_b_ready;
    logic                w_b_acc;
    logic                w_b_keep;
    logic                w_issue;
    logic                w_stall;
    logic [c_NREG-1:0]   w_clr_mask;
    logic [c_NREG-1:0]   w_set_mask;
    logic [c_NREG-1:0]   w_eff_busy;
    logic [c_NREG-1:0]   w_busy_nxt;

    // Writes to r0 are meaningless, so they never claim the port.
    assign w_a_req    = !rst && a_we && (a_waddr != '0);
    // The buffer only gets the port when the pipeline writeback is absent.
    assign w_drain    = !rst && !w_a_req && r_buf_v;
    // The buffer can take a new result when empty or when it empties this cycle.
    assign w_b_ready  = !rst && (!r_buf_v || w_drain);
    assign w_b_acc    = b_valid && w_b_ready;
    // Results for r0 are acknowledged but thrown away.
    assign w_b_keep   = w_b_acc && (b_waddr != '0);

    // The register being drained is no longer a hazard: its reader picks the
    // value up through the register file's write-to-read bypass.
    assign w_clr_mask = w_drain ? (c_ONE << r_buf_addr) : '0;
    assign w_eff_busy = r_busy & ~w_clr_mask;

    // RAW hazards on either read port, WAW hazard on the issued destination.
    always_comb begin
        w_stall = 1'b0;
        if (!rst) begin
            if (re1 && (raddr1 != '0) && w_eff_busy[raddr1])
                w_stall = 1'b1;
            if (re2 && (raddr2 != '0) && w_eff_busy[raddr2])
                w_stall = 1'b1;
            if (iss_valid && (iss_waddr != '0) && w_eff_busy[iss_waddr])
                w_stall = 1'b1;
        end
    end

    // A stalled issue is re-presented later, so it must not mark anything.
    assign w_issue    = iss_valid && (iss_waddr != '0) && !w_stall;
    assign w_set_mask = w_issue ? (c_ONE << iss_waddr) : '0;
    // Set is applied after clear so a same-cycle set on the drained index wins.
    assign w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & c_BIT0_MASK;

    // Write port mux: pipeline writeback first, then the buffer, else idle zeros.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_a_req) begin
            rf_we    = 1'b1;
            rf_waddr = a_waddr;
            rf_wdata = a_wdata;
        end else if (w_drain) begin
            rf_we    = 1'b1;
            rf_waddr = r_buf_addr;
            rf_wdata = r_buf_data;
        end
    end

    // Buffer: capture accepted results, empty after a drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_v    <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
        end else if (w_b_keep) begin
            r_buf_v    <= 1'b1;
            r_buf_addr <= b_waddr;
            r_buf_data <= b_wdata;
        end else if (w_drain) begin
            r_buf_v    <= 1'b0;
        end
    end

    // Scoreboard update; r0 is never marked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign b_ready = w_b_ready;
    assign stall_o = w_stall;
    assign busy_o  = rst ? '0 : r_busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed self-checking bench for wb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int c_DW = 32;
    localparam int c_AW = 5;

    logic              clk;
    logic              rst;
    logic              a_we;
    logic [c_AW-1:0]   a_waddr;
    logic [c_DW-1:0]   a_wdata;
    logic              b_valid;
    logic [c_AW-1:0]   b_waddr;
    logic [c_DW-1:0]   b_wdata;
    logic              b_ready;
    logic              iss_valid;
    logic [c_AW-1:0]   iss_waddr;
    logic              re1;
    logic              re2;
    logic [c_AW-1:0]   raddr1;
    logic [c_AW-1:0]   raddr2;
    logic              stall_o;
    logic              rf_we;
    logic [c_AW-1:0]   rf_waddr;
    logic [c_DW-1:0]   rf_wdata;
    logic [31:0]       busy_o;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter #(.DATA_W(c_DW), .ADDR_W(c_AW)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_waddr(iss_waddr),
        .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
        .stall_o(stall_o),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle, still well before the falling edge
    task automatic settle();
        #2;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [c_AW-1:0] wa,
                          input logic [c_DW-1:0] wd);
        chk({tag, ".we"},   rf_we,    we);
        chk({tag, ".addr"}, rf_waddr, wa);
        chk({tag, ".data"}, rf_wdata, wd);
    endtask

    initial begin
        rst = 1'b1; a_we = 0; a_waddr = 0; a_wdata = 0;
        b_valid = 0; b_waddr = 0; b_wdata = 0;
        iss_valid = 0; iss_waddr = 0;
        re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
        tick();
        // ---- reset state, even with an A request present
        a_we = 1; a_waddr = 3; a_wdata = 32'h55;
        settle();
        chk_wr("rst_wr", 1'b0, 0, 0);
        chk("rst_bready", b_ready, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_busy", busy_o, 0);
        tick();
        rst = 0; a_we = 0; a_waddr = 0; a_wdata = 0;
        settle();
        chk("first_rfwe", rf_we, 0);
        chk("first_bready", b_ready, 1);

        // ---- idle drain of r5
        iss_valid = 1; iss_waddr = 5;
        settle();
        chk("iss5_stall", stall_o, 0);
        tick();
        iss_valid = 0; iss_waddr = 0;
        settle();
        chk("iss5_busy", busy_o, 32'h20);
        tick();
        b_valid = 1; b_waddr = 5; b_wdata = 32'hDEADBEEF;
        settle();
        chk("b5_ready", b_ready, 1);
        chk("b5_nowr", rf_we, 0);
        tick();
        b_valid = 0; re1 = 1; raddr1 = 5;
        settle();
        chk_wr("drain5", 1'b1, 5, 32'hDEADBEEF);
        chk("drain5_busy", busy_o, 32'h20);
        chk("drain5_stall", stall_o, 0);
        tick();
        re1 = 0; raddr1 = 0;
        settle();
        chk("after5_busy", busy_o, 0);
        chk("after5_we", rf_we, 0);

        // ---- RAW stall on r9
        iss_valid = 1; iss_waddr = 9;
        tick();
        iss_valid = 0; iss_waddr = 0; re1 = 1; raddr1 = 9;
        settle();
        chk("raw9_re1", stall_o, 1);
        re1 = 0; re2 = 1; raddr2 = 9;
        settle();
        chk("raw9_re2", stall_o, 1);
        b_valid = 1; b_waddr = 9; b_wdata = 32'h99;
        settle();
        chk("raw9_acc_stall", stall_o, 1);
        chk("raw9_ready", b_ready, 1);
        tick();
        b_valid = 0;
        settle();
        chk("raw9_drain_stall", stall_o, 0);
        chk_wr("drain9", 1'b1, 9, 32'h99);
        tick();
        re2 = 0; raddr2 = 0;
        settle();
        chk("after9_busy", busy_o, 0);

        // ---- WAW on r4, stalled issue ignored, issue to r0
        iss_valid = 1; iss_waddr = 4;
        tick();
        settle();
        chk("waw4_stall", stall_o, 1);
        tick();
        iss_waddr = 8; re1 = 1; raddr1 = 4;
        settle();
        chk("rd4_stall", stall_o, 1);
        tick();
        re1 = 0; raddr1 = 0; iss_waddr = 0;
        settle();
        chk("stalled_iss_busy", busy_o, 32'h10);
        chk("iss0_stall", stall_o, 0);
        tick();
        iss_valid = 0;
        settle();
        chk("iss0_busy", busy_o, 32'h10);
        b_valid = 1; b_waddr = 4; b_wdata = 32'h44;
        tick();
        b_valid = 0; a_we = 1; a_waddr = 0; a_wdata = 32'hFF;
        settle();
        chk_wr("a0_drain4", 1'b1, 4, 32'h44);
        tick();
        a_we = 0;
        settle();
        chk("after4_busy", busy_o, 0);
        chk("after4_we", rf_we, 0);

        // ---- B result for r0: accepted and discarded
        b_valid = 1; b_waddr = 0; b_wdata = 32'hBAD;
        settle();
        chk("b0_ready", b_ready, 1);
        tick();
        b_valid = 0;
        settle();
        chk("b0_nowr", rf_we, 0);
        chk("b0_busy", busy_o, 0);

        // ---- conflict: buffered r7 waits out 3 cycles of A writes to r3
        iss_valid = 1; iss_waddr = 7;
        tick();
        iss_valid = 0; iss_waddr = 0;
        b_valid = 1; b_waddr = 7; b_wdata = 32'h11;
        tick();
        b_waddr = 8; b_wdata = 32'h88;
        a_we = 1; a_waddr = 3; a_wdata = 32'h22;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_wr($sformatf("hold%0d", i), 1'b1, 3, 32'h22);
            chk($sformatf("hold%0d_bready", i), b_ready, 0);
            tick();
        end
        a_we = 0; a_waddr = 0; a_wdata = 0;
        settle();
        chk_wr("drain7", 1'b1, 7, 32'h11);
        chk("drain7_bready", b_ready, 1);
        tick();
        b_valid = 0;
        settle();
        chk_wr("drain8", 1'b1, 8, 32'h88);
        chk("after7_busy", busy_o, 0);
        tick();

        // ---- A write to a busy register leaves busy alone
        iss_valid = 1; iss_waddr = 10;
        tick();
        iss_valid = 0; iss_waddr = 0;
        a_we = 1; a_waddr = 10; a_wdata = 32'hA;
        settle();
        chk_wr("a_busy10", 1'b1, 10, 32'hA);
        tick();
        a_we = 0;
        settle();
        chk("a_busy10_busy", busy_o, 32'h400);
        b_valid = 1; b_waddr = 10; b_wdata = 32'hAA;
        tick();
        b_valid = 0;
        tick();
        settle();
        chk("after10_busy", busy_o, 0);

        // ---- same-cycle set and clear on r6
        iss_valid = 1; iss_waddr = 6;
        tick();
        iss_valid = 0;
        b_valid = 1; b_waddr = 6; b_wdata = 32'h66;
        tick();
        b_valid = 0; iss_valid = 1; iss_waddr = 6;
        settle();
        chk("sc6_stall", stall_o, 0);
        chk_wr("sc6_drain", 1'b1, 6, 32'h66);
        tick();
        iss_valid = 0; iss_waddr = 0;
        settle();
        chk("sc6_busy", busy_o, 32'h40);
        b_valid = 1; b_waddr = 6; b_wdata = 32'h67;
        tick();
        b_valid = 0;
        tick();
        settle();
        chk("after6_busy", busy_o, 0);

        // ---- back-to-back B throughput while A idle
        b_valid = 1; b_waddr = 11; b_wdata = 32'hB11;
        tick();
        b_waddr = 12; b_wdata = 32'hB12;
        settle();
        chk("tp_ready", b_ready, 1);
        chk_wr("tp11", 1'b1, 11, 32'hB11);
        tick();
        b_valid = 0;
        settle();
        chk_wr("tp12", 1'b1, 12, 32'hB12);
        tick();

        // ---- reset mid-operation with a full buffer and busy r7, r9
        iss_valid = 1; iss_waddr = 7;
        tick();
        iss_waddr = 9;
        tick();
        iss_valid = 0; iss_waddr = 0;
        b_valid = 1; b_waddr = 7; b_wdata = 32'h77;
        settle();
        chk("pre_rst_busy", busy_o, 32'h280);
        tick();
        b_valid = 0; rst = 1;
        settle();
        chk("midrst_we", rf_we, 0);
        chk("midrst_busy", busy_o, 0);
        tick();
        rst = 0; re1 = 1; raddr1 = 7;
        settle();
        chk("postrst_we", rf_we, 0);
        chk("postrst_busy", busy_o, 0);
        chk("postrst_ready", b_ready, 1);
        chk("postrst_stall", stall_o, 0);
        tick();
        re1 = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
